// File: rtl/graphic_unit_sequencer.sv
// ---------------------------------------------------------------------------
// graphic_unit_sequencer
//
// Per-scanline scheduler for the graphic units (string, box/line, chart).
// On every accepted line request the sequencer walks a display list of
// N_UNITS entries in priority order (entry 0 first). It starts each unit
// whose vertical window covers the current line and passes that unit a
// window-relative dy. While a unit runs, its dx/wr/pixel stream is muxed
// onto the single line-buffer write port. When the list is exhausted,
// line_done pulses back to the display timing logic.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   line_start, line_y        new-line request pulse and absolute line number
//   line_done, busy           list finished pulse / line in progress
//   cfg_we, cfg_idx, cfg_en,  display-list shadow write port
//   cfg_y0, cfg_y1
//   unit_start, unit_dy       one-hot start pulse and window-relative line
//   unit_done, unit_dx,       per-unit done pulse, x position, write strobe
//   unit_wr, unit_pixel       and RGB565 pixel (unit i in slice i)
//   lb_addr, lb_wr, lb_data   registered line-buffer write port
//   timeout_err, err_idx      sticky abort flag and last aborted entry
//   overrun                   sticky: line_start arrived while busy
//
// Unit handshake: the sequencer pulses unit_start[i] for exactly one cycle.
// The unit then owns the line-buffer port until it pulses unit_done[i] for
// one cycle, or until TIMEOUT RUN cycles elapse and the unit is abandoned.
// A write presented in the same cycle as done is still forwarded. Inputs of
// every unit other than the one currently running are ignored.
// ---------------------------------------------------------------------------
module graphic_unit_sequencer #(
    parameter int N_UNITS = 4,
    parameter int LINE_W  = 320,
    parameter int TIMEOUT = 1023,
    localparam int IW     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  line_start,
    input  logic [11:0]           line_y,
    output logic                  line_done,
    output logic                  busy,
    input  logic                  cfg_we,
    input  logic [IW-1:0]         cfg_idx,
    input  logic                  cfg_en,
    input  logic [11:0]           cfg_y0,
    input  logic [11:0]           cfg_y1,
    output logic [N_UNITS-1:0]    unit_start,
    output logic [11:0]           unit_dy,
    input  logic [N_UNITS-1:0]    unit_done,
    input  logic [N_UNITS*12-1:0] unit_dx,
    input  logic [N_UNITS-1:0]    unit_wr,
    input  logic [N_UNITS*16-1:0] unit_pixel,
    output logic [11:0]           lb_addr,
    output logic                  lb_wr,
    output logic [15:0]           lb_data,
    output logic                  timeout_err,
    output logic [IW-1:0]         err_idx,
    output logic                  overrun
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [12:0]     LINE_W_C  = 13'(LINE_W);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(N_UNITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [11:0]          line_y_q;
    logic [CW-1:0]        cnt_q;

    // Shadow table is what software writes; active table is the snapshot
    // used by the line currently being sequenced.
    logic [N_UNITS-1:0]   shd_en_q, shd_en_d;
    logic [11:0]          shd_y0_q [N_UNITS];
    logic [11:0]          shd_y1_q [N_UNITS];
    logic [11:0]          shd_y0_d [N_UNITS];
    logic [11:0]          shd_y1_d [N_UNITS];
    logic [N_UNITS-1:0]   act_en_q;
    logic [11:0]          act_y0_q [N_UNITS];
    logic [11:0]          act_y1_q [N_UNITS];

    logic [N_UNITS-1:0]   unit_start_q;
    logic [11:0]          unit_dy_q;
    logic                 line_done_q;
    logic                 busy_q;
    logic [11:0]          lb_addr_q;
    logic                 lb_wr_q;
    logic [15:0]          lb_data_q;
    logic                 timeout_err_q;
    logic [IW-1:0]        err_idx_q;
    logic                 overrun_q;

    // Signals of the entry / unit selected by idx_q
    logic                 sel_elig;
    logic [11:0]          sel_y0;
    logic                 sel_done;
    logic                 sel_wr;
    logic [11:0]          sel_dx;
    logic [15:0]          sel_pix;
    logic                 idx_last;

    // Shadow next-state with the pending cfg write merged in, so a write in
    // the same cycle as an accepted line_start lands in the snapshot.
    always_comb begin
        shd_en_d = shd_en_q;
        shd_y0_d = shd_y0_q;
        shd_y1_d = shd_y1_q;
        if (cfg_we) begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (cfg_idx == IW'(i)) begin
                    shd_en_d[i] = cfg_en;
                    shd_y0_d[i] = cfg_y0;
                    shd_y1_d[i] = cfg_y1;
                end
            end
        end
    end

    always_comb begin
        sel_elig = 1'b0;
        sel_y0   = '0;
        sel_done = 1'b0;
        sel_wr   = 1'b0;
        sel_dx   = '0;
        sel_pix  = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (idx_q == IW'(i)) begin
                // y0 > y1 can never satisfy both bounds, so such a window
                // is naturally never eligible.
                sel_elig = act_en_q[i] && (act_y0_q[i] <= line_y_q) &&
                           (line_y_q <= act_y1_q[i]);
                sel_y0   = act_y0_q[i];
                sel_done = unit_done[i];
                sel_wr   = unit_wr[i];
                sel_dx   = unit_dx[12*i +: 12];
                sel_pix  = unit_pixel[16*i +: 16];
            end
        end
        idx_last = (idx_q == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            line_y_q      <= '0;
            cnt_q         <= '0;
            shd_en_q      <= '0;
            act_en_q      <= '0;
            for (int i = 0; i < N_UNITS; i++) begin
                shd_y0_q[i] <= '0;
                shd_y1_q[i] <= '0;
                act_y0_q[i] <= '0;
                act_y1_q[i] <= '0;
            end
            unit_start_q  <= '0;
            unit_dy_q     <= '0;
            line_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            lb_addr_q     <= '0;
            lb_wr_q       <= 1'b0;
            lb_data_q     <= '0;
            timeout_err_q <= 1'b0;
            err_idx_q     <= '0;
            overrun_q     <= 1'b0;
        end else begin
            shd_en_q <= shd_en_d;
            shd_y0_q <= shd_y0_d;
            shd_y1_q <= shd_y1_d;

            // Pulse outputs default low; the state that owns them raises them.
            unit_start_q <= '0;
            line_done_q  <= 1'b0;
            lb_wr_q      <= 1'b0;

            if (line_start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (line_start) begin
                        line_y_q <= line_y;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        act_en_q <= shd_en_d;
                        act_y0_q <= shd_y0_d;
                        act_y1_q <= shd_y1_d;
                        state_q  <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (sel_elig) begin
                        unit_start_q <= N_UNITS'(1) << idx_q;
                        unit_dy_q    <= line_y_q - sel_y0;
                        state_q      <= S_START;
                    end else if (idx_last) begin
                        line_done_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q        <= idx_q + 1'b1;
                    end
                end

                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end

                S_RUN: begin
                    lb_wr_q <= sel_wr && ({1'b0, sel_dx} < LINE_W_C);
                    if (sel_wr) begin
                        lb_addr_q <= sel_dx;
                        lb_data_q <= sel_pix;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    // The unit gets exactly TIMEOUT RUN cycles to report done.
                    if (sel_done || (cnt_q == TO_LAST)) begin
                        if (!sel_done) begin
                            timeout_err_q <= 1'b1;
                            err_idx_q     <= idx_q;
                        end
                        if (idx_last) begin
                            line_done_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            state_q     <= S_SCAN;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign unit_start  = unit_start_q;
    assign unit_dy     = unit_dy_q;
    assign line_done   = line_done_q;
    assign busy        = busy_q;
    assign lb_addr     = lb_addr_q;
    assign lb_wr       = lb_wr_q;
    assign lb_data     = lb_data_q;
    assign timeout_err = timeout_err_q;
    assign err_idx     = err_idx_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_graphic_unit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_graphic_unit_sequencer
//
// The whole run is planned up front on an absolute cycle timeline. The
// planner keeps its own shadow/active display list and, for every line,
// walks the list with plain arithmetic (one cycle per skipped entry, two
// cycles of scan+start before a run, run length from the scripted unit
// behaviour), producing both the unit stimulus and the expected outputs.
// A single negedge process compares the DUT against the timeline.
// ---------------------------------------------------------------------------
module tb_graphic_unit_sequencer;

    localparam int N    = 4;
    localparam int LW   = 320;
    localparam int TO   = 16;
    localparam int MAXC = 160;
    localparam int LAST = 132;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              line_start;
    logic [11:0]       line_y;
    logic              line_done;
    logic              busy;
    logic              cfg_we;
    logic [1:0]        cfg_idx;
    logic              cfg_en;
    logic [11:0]       cfg_y0;
    logic [11:0]       cfg_y1;
    logic [N-1:0]      unit_start;
    logic [11:0]       unit_dy;
    logic [N-1:0]      unit_done;
    logic [N*12-1:0]   unit_dx;
    logic [N-1:0]      unit_wr;
    logic [N*16-1:0]   unit_pixel;
    logic [11:0]       lb_addr;
    logic              lb_wr;
    logic [15:0]       lb_data;
    logic              timeout_err;
    logic [1:0]        err_idx;
    logic              overrun;

    graphic_unit_sequencer #(
        .N_UNITS (N),
        .LINE_W  (LW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .line_start  (line_start),
        .line_y      (line_y),
        .line_done   (line_done),
        .busy        (busy),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_y0      (cfg_y0),
        .cfg_y1      (cfg_y1),
        .unit_start  (unit_start),
        .unit_dy     (unit_dy),
        .unit_done   (unit_done),
        .unit_dx     (unit_dx),
        .unit_wr     (unit_wr),
        .unit_pixel  (unit_pixel),
        .lb_addr     (lb_addr),
        .lb_wr       (lb_wr),
        .lb_data     (lb_data),
        .timeout_err (timeout_err),
        .err_idx     (err_idx),
        .overrun     (overrun)
    );

    // ---------------- stimulus timeline ----------------
    logic            s_rst_n      [MAXC];
    logic            s_line_start [MAXC];
    logic [11:0]     s_line_y     [MAXC];
    logic            s_cfg_we     [MAXC];
    logic [1:0]      s_cfg_idx    [MAXC];
    logic            s_cfg_en     [MAXC];
    logic [11:0]     s_cfg_y0     [MAXC];
    logic [11:0]     s_cfg_y1     [MAXC];
    logic [N-1:0]    s_unit_done  [MAXC];
    logic [N-1:0]    s_unit_wr    [MAXC];
    logic [N*12-1:0] s_unit_dx    [MAXC];
    logic [N*16-1:0] s_unit_pix   [MAXC];

    // ---------------- expected timeline ----------------
    logic [N-1:0]    e_unit_start [MAXC];
    logic            e_line_done  [MAXC];
    logic            e_busy       [MAXC];
    logic            e_lb_wr      [MAXC];
    logic [11:0]     e_lb_addr    [MAXC];
    logic [15:0]     e_lb_data    [MAXC];
    logic            e_dy_valid   [MAXC];
    logic [11:0]     e_dy         [MAXC];
    logic            e_zero       [MAXC];
    logic            ev_te        [MAXC];
    logic [1:0]      ev_te_idx    [MAXC];
    logic            ev_ov        [MAXC];
    logic            e_te         [MAXC];
    logic [1:0]      e_eidx       [MAXC];
    logic            e_ov         [MAXC];

    // ---------------- model display list ----------------
    logic            m_shd_en [N];
    logic [11:0]     m_shd_y0 [N];
    logic [11:0]     m_shd_y1 [N];
    logic            m_act_en [N];
    logic [11:0]     m_act_y0 [N];
    logic [11:0]     m_act_y1 [N];

    // Scripted unit behaviour for the next planned line.
    // done_off < 0 means the unit never reports done.
    int              b_done_off [N];
    int              b_nwr      [N];
    int              b_wr_off   [N][4];
    logic [11:0]     b_wr_dx    [N][4];
    logic [15:0]     b_wr_pix   [N][4];
    int              run_start  [N];

    int              cyc = 0;
    logic            run_on = 1'b0;
    int              total = 0;
    int              bad = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic init_plan();
        for (int c = 0; c < MAXC; c++) begin
            s_rst_n[c]      = (c > 2);
            s_line_start[c] = 1'b0;
            s_line_y[c]     = '0;
            s_cfg_we[c]     = 1'b0;
            s_cfg_idx[c]    = '0;
            s_cfg_en[c]     = 1'b0;
            s_cfg_y0[c]     = '0;
            s_cfg_y1[c]     = '0;
            s_unit_done[c]  = '0;
            s_unit_wr[c]    = '0;
            s_unit_dx[c]    = '0;
            s_unit_pix[c]   = '0;
            e_unit_start[c] = '0;
            e_line_done[c]  = 1'b0;
            e_busy[c]       = 1'b0;
            e_lb_wr[c]      = 1'b0;
            e_lb_addr[c]    = '0;
            e_lb_data[c]    = '0;
            e_dy_valid[c]   = 1'b0;
            e_dy[c]         = '0;
            e_zero[c]       = 1'b0;
            ev_te[c]        = 1'b0;
            ev_te_idx[c]    = '0;
            ev_ov[c]        = 1'b0;
            e_te[c]         = 1'b0;
            e_eidx[c]       = '0;
            e_ov[c]         = 1'b0;
        end
        clear_tables();
        clear_beh();
    endtask

    task automatic clear_tables();
        for (int i = 0; i < N; i++) begin
            m_shd_en[i] = 1'b0; m_shd_y0[i] = '0; m_shd_y1[i] = '0;
            m_act_en[i] = 1'b0; m_act_y0[i] = '0; m_act_y1[i] = '0;
        end
    endtask

    task automatic clear_beh();
        for (int i = 0; i < N; i++) begin
            b_done_off[i] = 0;
            b_nwr[i]      = 0;
            run_start[i]  = 0;
        end
    endtask

    task automatic add_wr(input int u, input int off, input logic [11:0] dx, input logic [15:0] pix);
        b_wr_off[u][b_nwr[u]] = off;
        b_wr_dx[u][b_nwr[u]]  = dx;
        b_wr_pix[u][b_nwr[u]] = pix;
        b_nwr[u]++;
    endtask

    task automatic plan_cfg(input int c, input int idx, input logic en,
                            input logic [11:0] y0, input logic [11:0] y1);
        s_cfg_we[c]  = 1'b1;
        s_cfg_idx[c] = 2'(idx);
        s_cfg_en[c]  = en;
        s_cfg_y0[c]  = y0;
        s_cfg_y1[c]  = y1;
        m_shd_en[idx] = en;
        m_shd_y0[idx] = y0;
        m_shd_y1[idx] = y1;
    endtask

    // Lays out one line starting at cycle t; returns the line_done cycle.
    task automatic plan_line(input int t, input logic [11:0] y, output int done_c);
        int c;
        int run0;
        int len;
        int off;
        s_line_start[t] = 1'b1;
        s_line_y[t]     = y;
        for (int i = 0; i < N; i++) begin
            m_act_en[i] = m_shd_en[i];
            m_act_y0[i] = m_shd_y0[i];
            m_act_y1[i] = m_shd_y1[i];
        end
        c = t + 1;
        for (int i = 0; i < N; i++) begin
            if (m_act_en[i] && (m_act_y0[i] <= y) && (y <= m_act_y1[i])) begin
                run0 = c + 2;
                len  = (b_done_off[i] >= 0) ? b_done_off[i] + 1 : TO;
                e_unit_start[c + 1][i] = 1'b1;
                for (int k = c + 1; k < run0 + len; k++) begin
                    e_dy_valid[k] = 1'b1;
                    e_dy[k]       = y - m_act_y0[i];
                end
                if (b_done_off[i] >= 0) begin
                    s_unit_done[run0 + b_done_off[i]][i] = 1'b1;
                end else begin
                    ev_te[run0 + len - 1]     = 1'b1;
                    ev_te_idx[run0 + len - 1] = 2'(i);
                end
                for (int w = 0; w < b_nwr[i]; w++) begin
                    off = b_wr_off[i][w];
                    if (off < len) begin
                        s_unit_wr[run0 + off][i]              = 1'b1;
                        s_unit_dx[run0 + off][12*i +: 12]     = b_wr_dx[i][w];
                        s_unit_pix[run0 + off][16*i +: 16]    = b_wr_pix[i][w];
                        if (int'(b_wr_dx[i][w]) < LW) begin
                            e_lb_wr[run0 + off + 1]   = 1'b1;
                            e_lb_addr[run0 + off + 1] = b_wr_dx[i][w];
                            e_lb_data[run0 + off + 1] = b_wr_pix[i][w];
                        end
                    end
                end
                run_start[i] = run0;
                c = run0 + len;
            end else begin
                c = c + 1;
            end
        end
        e_line_done[c] = 1'b1;
        for (int k = t + 1; k <= c; k++) e_busy[k] = 1'b1;
        done_c = c;
    endtask

    task automatic plan_extra_start(input int c, input logic [11:0] y);
        s_line_start[c] = 1'b1;
        s_line_y[c]     = y;
        if (e_busy[c]) ev_ov[c] = 1'b1;
    endtask

    // Reset at cycle r wipes everything the line in flight would have done.
    task automatic plan_reset(input int r);
        s_rst_n[r] = 1'b0;
        ev_te[r]   = 1'b0;
        ev_ov[r]   = 1'b0;
        for (int c = r + 1; c < MAXC; c++) begin
            e_unit_start[c] = '0;
            e_line_done[c]  = 1'b0;
            e_busy[c]       = 1'b0;
            e_lb_wr[c]      = 1'b0;
            e_dy_valid[c]   = 1'b0;
            ev_te[c]        = 1'b0;
            ev_ov[c]        = 1'b0;
            s_unit_done[c]  = '0;
            s_unit_wr[c]    = '0;
        end
        clear_tables();
    endtask

    task automatic finalize();
        logic te;
        logic [1:0] ei;
        logic ov;
        te = 1'b0; ei = '0; ov = 1'b0;
        for (int c = 1; c < MAXC; c++) begin
            if (!s_rst_n[c - 1]) begin
                te = 1'b0; ei = '0; ov = 1'b0;
                e_zero[c] = 1'b1;
            end else begin
                if (ev_te[c - 1]) begin
                    te = 1'b1;
                    ei = ev_te_idx[c - 1];
                end
                if (ev_ov[c - 1]) ov = 1'b1;
            end
            e_te[c]   = te;
            e_eidx[c] = ei;
            e_ov[c]   = ov;
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input int c);
        reset_n    = s_rst_n[c];
        line_start = s_line_start[c];
        line_y     = s_line_y[c];
        cfg_we     = s_cfg_we[c];
        cfg_idx    = s_cfg_idx[c];
        cfg_en     = s_cfg_en[c];
        cfg_y0     = s_cfg_y0[c];
        cfg_y1     = s_cfg_y1[c];
        unit_done  = s_unit_done[c];
        unit_wr    = s_unit_wr[c];
        unit_dx    = s_unit_dx[c];
        unit_pixel = s_unit_pix[c];
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (run_on && (cyc >= 1) && (cyc <= LAST)) begin
            if (e_zero[cyc]) begin
                chk("rst_unit_start", 32'(unit_start), 32'd0);
                chk("rst_unit_dy", 32'(unit_dy), 32'd0);
                chk("rst_line_done", 32'(line_done), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_lb_wr", 32'(lb_wr), 32'd0);
                chk("rst_lb_addr", 32'(lb_addr), 32'd0);
                chk("rst_lb_data", 32'(lb_data), 32'd0);
                chk("rst_timeout_err", 32'(timeout_err), 32'd0);
                chk("rst_err_idx", 32'(err_idx), 32'd0);
                chk("rst_overrun", 32'(overrun), 32'd0);
            end else begin
                chk("unit_start", 32'(unit_start), 32'(e_unit_start[cyc]));
                chk("line_done", 32'(line_done), 32'(e_line_done[cyc]));
                chk("busy", 32'(busy), 32'(e_busy[cyc]));
                chk("lb_wr", 32'(lb_wr), 32'(e_lb_wr[cyc]));
                chk("timeout_err", 32'(timeout_err), 32'(e_te[cyc]));
                chk("err_idx", 32'(err_idx), 32'(e_eidx[cyc]));
                chk("overrun", 32'(overrun), 32'(e_ov[cyc]));
                if (e_dy_valid[cyc]) chk("unit_dy", 32'(unit_dy), 32'(e_dy[cyc]));
                if (e_lb_wr[cyc]) begin
                    chk("lb_addr", 32'(lb_addr), 32'(e_lb_addr[cyc]));
                    chk("lb_data", 32'(lb_data), 32'(e_lb_data[cyc]));
                end
            end
        end
    end

    // ---------------- directed plan and run ----------------
    initial begin
        int d1, d2, d3, d4, d5, d6, d7, d8, d9;
        init_plan();

        // Line 1: empty table.
        plan_line(5, 12'd5, d1);

        // Line 2: entry 1 covers line 15, unit writes dx 0..3.
        plan_cfg(12, 1, 1'b1, 12'd10, 12'd20);
        clear_beh();
        b_done_off[1] = 5;
        for (int k = 0; k < 4; k++) add_wr(1, k, 12'(k), 16'hF800);
        plan_line(14, 12'd15, d2);

        // Line 3: entries 0 and 2 both cover 100; dx 320 is dropped.
        plan_cfg(28, 1, 1'b0, 12'd10, 12'd20);
        plan_cfg(29, 0, 1'b1, 12'd90, 12'd110);
        plan_cfg(30, 2, 1'b1, 12'd100, 12'd100);
        clear_beh();
        b_done_off[0] = 2;
        b_done_off[2] = 2;
        add_wr(2, 0, 12'd320, 16'h1111);
        add_wr(2, 1, 12'd319, 16'h1234);
        plan_line(32, 12'd100, d3);
        // Unit 3 is not running: its done and write must be ignored.
        s_unit_done[run_start[0]][3]        = 1'b1;
        s_unit_wr[run_start[0]][3]          = 1'b1;
        s_unit_dx[run_start[0]][36 +: 12]   = 12'd7;
        s_unit_pix[run_start[0]][48 +: 16]  = 16'h0F0F;

        // Line 4: entry 3 never reports done -> timeout.
        plan_cfg(47, 0, 1'b0, 12'd90, 12'd110);
        plan_cfg(48, 2, 1'b0, 12'd100, 12'd100);
        plan_cfg(49, 3, 1'b1, 12'd0, 12'd4095);
        clear_beh();
        b_done_off[3] = -1;
        add_wr(3, 3, 12'd50, 16'hABCD);
        plan_line(51, 12'd200, d4);

        // Line 5: normal empty line after the timeout.
        plan_cfg(75, 3, 1'b0, 12'd0, 12'd4095);
        clear_beh();
        plan_line(77, 12'd200, d5);

        // Line 6: mid-line cfg write and an overrun line_start.
        plan_cfg(84, 0, 1'b1, 12'd0, 12'd50);
        clear_beh();
        b_done_off[0] = 4;
        add_wr(0, 1, 12'd100, 16'h07E0);
        plan_line(86, 12'd30, d6);
        plan_cfg(90, 0, 1'b0, 12'd0, 12'd50);
        plan_extra_start(91, 12'd7);

        // Line 7: cfg write in the same cycle as line_start, write in done cycle.
        plan_cfg(100, 1, 1'b1, 12'd30, 12'd30);
        clear_beh();
        b_done_off[1] = 0;
        add_wr(1, 0, 12'd8, 16'h001F);
        plan_line(100, 12'd30, d7);

        // Line 8: reset during RUN, then a line on the cleared table.
        plan_cfg(109, 2, 1'b1, 12'd0, 12'd100);
        clear_beh();
        b_done_off[2] = 10;
        add_wr(2, 1, 12'd5, 16'h5555);
        add_wr(2, 2, 12'd6, 16'h6666);
        plan_line(111, 12'd40, d8);
        plan_reset(118);
        clear_beh();
        plan_line(121, 12'd40, d9);

        finalize();

        // Hand-computed pins on the planned timeline.
        chk("pin_empty_done", 32'(d1), 32'd10);
        chk("pin_start_u1", 32'(e_unit_start[17]), 32'h2);
        chk("pin_dy_u1", 32'(e_dy[17]), 32'd5);
        chk("pin_wr_first", 32'(e_lb_wr[19]), 32'd1);
        chk("pin_addr_last", 32'(e_lb_addr[22]), 32'd3);
        chk("pin_line2_done", 32'(d2), 32'd26);
        chk("pin_dy_u0", 32'(e_dy[34]), 32'd10);
        chk("pin_drop_320", 32'(e_lb_wr[42]), 32'd0);
        chk("pin_keep_319", 32'(e_lb_addr[43]), 32'd319);
        chk("pin_line3_done", 32'(d3), 32'd45);
        chk("pin_to_done", 32'(d4), 32'd73);
        chk("pin_to_flag", 32'(e_te[73]), 32'd1);
        chk("pin_ov_flag", 32'(e_ov[92]), 32'd1);
        chk("pin_same_cycle_cfg", 32'(d7), 32'd107);
        chk("pin_post_reset_done", 32'(d9), 32'd126);
        chk("pin_reset_zero", 32'(e_zero[119]), 32'd1);

        cyc = 0;
        apply(0);
        run_on = 1'b1;
        while (cyc < LAST) begin
            @(posedge clk);
            #1;
            cyc++;
            apply(cyc);
        end
        @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/graphic_unit_sequencer.md
Name: graphic_unit_sequencer

Overview:
Per-scanline scheduler for the graphic units (string, box/line, chart).
- On each line request, walks a display list of N_UNITS entries in priority order (index 0 first).
- Starts each unit whose vertical window covers the current line and hands it a window-relative dy.
- Muxes the running unit's dx/wr/pixel stream onto the single line-buffer write port.
- Reports line completion to the display timing logic.

Parameters:
N_UNITS, 4, number of graphic units sequenced (index width IW = clog2(N_UNITS), minimum 1)
LINE_W, 320, pixels per line; writes with dx >= LINE_W are dropped
TIMEOUT, 1023, maximum cycles a unit may stay in RUN before it is aborted

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
line_start  in  1  one-cycle pulse requesting a new line
line_y  in  12  absolute line number, sampled with line_start
line_done  out  1  one-cycle pulse when the list is finished
busy  out  1  high from the cycle after an accepted line_start through DONE
cfg_we  in  1  display-list write strobe
cfg_idx  in  IW  entry index
cfg_en  in  1  entry enable
cfg_y0  in  12  window top, inclusive
cfg_y1  in  12  window bottom, inclusive
unit_start  out  N_UNITS  one-hot start pulse
unit_dy  out  12  line_y - y0 of the selected unit, stable from START through RUN
unit_done  in  N_UNITS  per-unit done pulse
unit_dx  in  N_UNITS*12  per-unit x position; unit i occupies bits [12i+11:12i]
unit_wr  in  N_UNITS  per-unit write strobe
unit_pixel  in  N_UNITS*16  per-unit RGB565 pixel
lb_addr  out  12  line-buffer write address
lb_wr  out  1  line-buffer write enable
lb_data  out  16  line-buffer write data
timeout_err  out  1  sticky: a unit was aborted
err_idx  out  IW  index of the most recently aborted unit
overrun  out  1  sticky: line_start arrived while busy

Behaviour:
- Reset (reset_n low at a clk edge) wins over all other inputs:
  - all outputs 0; state IDLE.
  - shadow and active tables cleared (all entries disabled); timeout counter 0.
- Reset mid-line aborts immediately. No line_done is issued, and no unit_start is issued afterwards.
- Config path:
  - cfg_we writes the shadow entry at cfg_idx in any state.
  - At an accepted line_start, the whole shadow table is copied to the active table, so mid-line writes affect only the next line.
  - A write in the same cycle as an accepted line_start is included in the copy.
- Eligibility of entry i: en && y0 <= line_y <= y1, unsigned compare. y0 > y1 means never eligible.
- IDLE:
  - line_start -> latch line_y, idx = 0, go to SCAN.
  - If line_start is seen in any other state, it is ignored and overrun is set.
- SCAN, one entry per cycle:
  - Entry idx eligible -> START.
  - Else if idx == N_UNITS-1 -> DONE.
  - Else idx++.
- START, one cycle:
  - unit_start[idx] = 1; unit_dy = line_y - y0[idx] (12-bit); timeout counter cleared.
  - Next state RUN.
- RUN:
  - Write path is registered with 1-cycle latency: lb_wr <= unit_wr[idx] && (unit_dx[idx] < LINE_W); lb_addr <= unit_dx[idx]; lb_data <= unit_pixel[idx].
  - Inputs of non-selected units are ignored, including their done.
  - unit_done[idx] -> next entry (idx++ and SCAN), or DONE if idx == N_UNITS-1.
  - A write presented in the done cycle is still forwarded.
  - Counter reaches TIMEOUT without done -> set timeout_err, err_idx = idx, leave the unit, advance as above.
- DONE: line_done = 1 for one cycle; busy = 0; go to IDLE.
- lb_wr is 0 in every cycle not fed by a RUN-cycle write. lb_addr and lb_data hold their last values.
- Line with no eligible entries: line_start at cycle T, line_done at cycle T+N_UNITS+1.

Test Plan:
- Reset then line_start with line_y=5 and an empty table -> no unit_start; line_done exactly 5 cycles later (N_UNITS=4); all lb_wr = 0.
- Entry 1 = {en=1, y0=10, y1=20}; line_y=15 -> unit_start=4'b0010 one cycle; unit_dy=5. Unit writes dx=0..3 with pixel 16'hF800 -> lb_wr 4 cycles at addr 0..3, data F800, each 1 cycle after unit_wr. done -> line_done follows after the remaining scan.
- Entries 0 and 2 both cover line_y=100 -> unit 0 starts and completes before unit 2 starts. unit_done[3] pulsed during unit 0's RUN has no effect. A write at dx=320 by unit 2 -> lb_wr stays 0.
- Entry 3 never asserts done, TIMEOUT=16 -> after 16 RUN cycles timeout_err=1, err_idx=3, line_done pulses, next line proceeds normally.
- cfg write disabling entry 0 during a busy line -> current line still runs unit 0. Second line_start while busy -> overrun=1 and the line is not restarted. Next line skips unit 0.
- reset_n low during RUN -> next cycle all outputs 0. Subsequent line_start with an unwritten table -> no unit_start.
